// File: rtl/ex_stage.sv
// Execute stage: RV32I ALU, single-cycle RV32M multiply, iterative restoring divider.
module ex_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DIV_ITER = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ID_EX_Valid,
    input  logic [XLEN-1:0] ID_EX_Rs1Data,
    input  logic [XLEN-1:0] ID_EX_Rs2Data,
    input  logic [XLEN-1:0] ID_EX_Imm,
    input  logic            ID_EX_ALUSrc,
    input  logic [3:0]      ID_EX_ALUOp,
    input  logic [4:0]      ID_EX_Rd,
    input  logic            ID_EX_RegWrite,
    input  logic            ID_EX_MemRead,
    input  logic            ID_EX_MemWrite,
    input  logic            mem_stall,
    output logic [XLEN-1:0] EX_MEM_ALUResult,
    output logic [XLEN-1:0] EX_MEM_WriteData,
    output logic [4:0]      EX_MEM_Rd,
    output logic            EX_MEM_RegWrite,
    output logic            EX_MEM_MemRead,
    output logic            EX_MEM_MemWrite,
    output logic            ex_busy
);

    localparam int unsigned CNT_W = $clog2(DIV_ITER);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t        state;
    logic [CNT_W-1:0]  div_cnt;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_den;
    logic [XLEN-1:0]   div_wd;
    logic              div_neg_q;
    logic              div_neg_r;
    logic              div_is_rem;
    logic [4:0]        div_rd;
    logic              div_rw;
    logic              div_mr;
    logic              div_mw;

    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [4:0]        shamt;
    logic [2*XLEN-1:0] mul_full;
    logic              is_div_op;
    logic              div_signed;
    logic              is_rem;
    logic              div_by_zero;
    logic              div_ovf;
    logic              div_special;
    logic              start;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   div_result;

    // Operand selection, divide classification and the accept condition.
    always_comb begin
        op_a        = ID_EX_Rs1Data;
        op_b        = ID_EX_ALUSrc ? ID_EX_Imm : ID_EX_Rs2Data;
        shamt       = op_b[4:0];
        mul_full    = {{XLEN{op_a[XLEN-1]}}, op_a} * {{XLEN{op_b[XLEN-1]}}, op_b};
        is_div_op   = (ID_EX_ALUOp[3:2] == 2'b11);
        div_signed  = ~ID_EX_ALUOp[0];
        is_rem      = ID_EX_ALUOp[1];
        div_by_zero = (op_b == '0);
        div_ovf     = div_signed && (op_a == INT_MIN) && (op_b == '1);
        div_special = div_by_zero | div_ovf;
        // Reset gating keeps ex_busy equal to mem_stall while reset is held.
        start       = reset_n && ID_EX_Valid && is_div_op && !div_special && (state == S_IDLE);
        a_abs       = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
        b_abs       = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;
    end

    // Single-cycle result, including the divide special cases.
    always_comb begin
        alu_result = '0;
        case (ID_EX_ALUOp)
            4'd0:  alu_result = op_a + op_b;
            4'd1:  alu_result = op_a - op_b;
            4'd2:  alu_result = op_a << shamt;
            4'd3:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd4:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'd5:  alu_result = op_a ^ op_b;
            4'd6:  alu_result = op_a >> shamt;
            4'd7:  alu_result = $unsigned($signed(op_a) >>> shamt);
            4'd8:  alu_result = op_a | op_b;
            4'd9:  alu_result = op_a & op_b;
            4'd10: alu_result = mul_full[XLEN-1:0];
            4'd11: alu_result = mul_full[2*XLEN-1:XLEN];
            default: begin
                if (div_by_zero) alu_result = is_rem ? op_a : '1;
                else             alu_result = is_rem ? '0 : INT_MIN;
            end
        endcase
    end

    // One restoring shift-subtract step and the final sign correction.
    always_comb begin
        div_shift  = {div_rem, div_quo[XLEN-1]};
        div_diff   = div_shift - {1'b0, div_den};
        q_fix      = div_neg_q ? -div_quo : div_quo;
        r_fix      = div_neg_r ? -div_rem : div_rem;
        div_result = div_is_rem ? r_fix : q_fix;
    end

    // Front end must hold while MEM stalls or a divide is being accepted or iterated.
    assign ex_busy = mem_stall | start | (state == S_BUSY);

    // Divider FSM and the EX_MEM pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            div_cnt          <= '0;
            div_quo          <= '0;
            div_rem          <= '0;
            div_den          <= '0;
            div_wd           <= '0;
            div_neg_q        <= 1'b0;
            div_neg_r        <= 1'b0;
            div_is_rem       <= 1'b0;
            div_rd           <= '0;
            div_rw           <= 1'b0;
            div_mr           <= 1'b0;
            div_mw           <= 1'b0;
            EX_MEM_ALUResult <= '0;
            EX_MEM_WriteData <= '0;
            EX_MEM_Rd        <= '0;
            EX_MEM_RegWrite  <= 1'b0;
            EX_MEM_MemRead   <= 1'b0;
            EX_MEM_MemWrite  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_quo    <= a_abs;
                        div_rem    <= '0;
                        div_den    <= b_abs;
                        div_wd     <= ID_EX_Rs2Data;
                        div_neg_q  <= div_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        div_neg_r  <= div_signed & op_a[XLEN-1];
                        div_is_rem <= is_rem;
                        div_rd     <= ID_EX_Rd;
                        div_rw     <= ID_EX_RegWrite;
                        div_mr     <= ID_EX_MemRead;
                        div_mw     <= ID_EX_MemWrite;
                        div_cnt    <= CNT_W'(DIV_ITER - 1);
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!div_diff[XLEN]) begin
                        div_rem <= div_diff[XLEN-1:0];
                        div_quo <= {div_quo[XLEN-2:0], 1'b1};
                    end else begin
                        div_rem <= div_shift[XLEN-1:0];
                        div_quo <= {div_quo[XLEN-2:0], 1'b0};
                    end
                    div_cnt <= div_cnt - CNT_W'(1);
                    if (div_cnt == '0) state <= S_DONE;
                end
                S_DONE: begin
                    if (!mem_stall) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (!mem_stall) begin
                if (state == S_DONE) begin
                    EX_MEM_ALUResult <= div_result;
                    EX_MEM_WriteData <= div_wd;
                    EX_MEM_Rd        <= div_rd;
                    EX_MEM_RegWrite  <= div_rw;
                    EX_MEM_MemRead   <= div_mr;
                    EX_MEM_MemWrite  <= div_mw;
                end else if ((state == S_BUSY) || start || !ID_EX_Valid) begin
                    EX_MEM_ALUResult <= '0;
                    EX_MEM_WriteData <= '0;
                    EX_MEM_Rd        <= '0;
                    EX_MEM_RegWrite  <= 1'b0;
                    EX_MEM_MemRead   <= 1'b0;
                    EX_MEM_MemWrite  <= 1'b0;
                end else begin
                    EX_MEM_ALUResult <= alu_result;
                    EX_MEM_WriteData <= ID_EX_Rs2Data;
                    EX_MEM_Rd        <= ID_EX_Rd;
                    EX_MEM_RegWrite  <= ID_EX_RegWrite;
                    EX_MEM_MemRead   <= ID_EX_MemRead;
                    EX_MEM_MemWrite  <= ID_EX_MemWrite;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors, queued expectations, negedge monitor.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ID_EX_Valid;
    logic [31:0] ID_EX_Rs1Data;
    logic [31:0] ID_EX_Rs2Data;
    logic [31:0] ID_EX_Imm;
    logic        ID_EX_ALUSrc;
    logic [3:0]  ID_EX_ALUOp;
    logic [4:0]  ID_EX_Rd;
    logic        ID_EX_RegWrite;
    logic        ID_EX_MemRead;
    logic        ID_EX_MemWrite;
    logic        mem_stall;
    logic [31:0] EX_MEM_ALUResult;
    logic [31:0] EX_MEM_WriteData;
    logic [4:0]  EX_MEM_Rd;
    logic        EX_MEM_RegWrite;
    logic        EX_MEM_MemRead;
    logic        EX_MEM_MemWrite;
    logic        ex_busy;

    ex_stage #(.XLEN(32), .DIV_ITER(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ID_EX_Valid      (ID_EX_Valid),
        .ID_EX_Rs1Data    (ID_EX_Rs1Data),
        .ID_EX_Rs2Data    (ID_EX_Rs2Data),
        .ID_EX_Imm        (ID_EX_Imm),
        .ID_EX_ALUSrc     (ID_EX_ALUSrc),
        .ID_EX_ALUOp      (ID_EX_ALUOp),
        .ID_EX_Rd         (ID_EX_Rd),
        .ID_EX_RegWrite   (ID_EX_RegWrite),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_MemWrite   (ID_EX_MemWrite),
        .mem_stall        (mem_stall),
        .EX_MEM_ALUResult (EX_MEM_ALUResult),
        .EX_MEM_WriteData (EX_MEM_WriteData),
        .EX_MEM_Rd        (EX_MEM_Rd),
        .EX_MEM_RegWrite  (EX_MEM_RegWrite),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_MemWrite  (EX_MEM_MemWrite),
        .ex_busy          (ex_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sbq[$];
    int   vecs   = 0;
    int   errs   = 0;
    int   cyc    = 0;
    int   next_id = 0;
    logic ld     = 1'b0;

    // Cycle counter and "EX_MEM was allowed to load at this edge" flag.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ld  <= reset_n && !mem_stall;
    end

    // Monitor: every non-bubble load must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ld && (EX_MEM_RegWrite || EX_MEM_MemRead || EX_MEM_MemWrite)) begin
            vecs++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL unexpected_output: got res=%h rd=%0d ctl=%b%b%b at cycle %0d, required a bubble",
                         EX_MEM_ALUResult, EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (EX_MEM_ALUResult !== e.res || EX_MEM_WriteData !== e.wd || EX_MEM_Rd !== e.rd ||
                    EX_MEM_RegWrite !== e.rw || EX_MEM_MemRead !== e.mr || EX_MEM_MemWrite !== e.mw ||
                    cyc != e.cyc) begin
                    errs++;
                    $display("FAIL vec%0d: got res=%h wd=%h rd=%0d ctl=%b%b%b cyc=%0d, required res=%h wd=%h rd=%0d ctl=%b%b%b cyc=%0d",
                             e.id, EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_Rd,
                             EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, cyc,
                             e.res, e.wd, e.rd, e.rw, e.mr, e.mw, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw,
                         input logic [31:0] exp_res, input int lat);
        exp_t e;
        ID_EX_Valid    = 1'b1;
        ID_EX_ALUOp    = op;
        ID_EX_Rs1Data  = a;
        ID_EX_Rs2Data  = rs2;
        ID_EX_Imm      = imm;
        ID_EX_ALUSrc   = src;
        ID_EX_Rd       = rd;
        ID_EX_RegWrite = rw;
        ID_EX_MemRead  = mr;
        ID_EX_MemWrite = mw;
        e.res = exp_res; e.wd = rs2; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw;
        e.cyc = cyc + lat; e.id = next_id;
        next_id++;
        sbq.push_back(e);
    endtask

    // Returns once the presented instruction was taken; counts cycles with ex_busy high.
    task automatic wait_accept(output int nbusy);
        logic b;
        nbusy = 0;
        forever begin
            @(negedge clk);
            b = ex_busy;
            @(posedge clk);
            #1;
            if (!b) break;
            nbusy++;
            if (nbusy > 200) begin
                vecs++;
                errs++;
                $display("FAIL accept_timeout: got ex_busy stuck for %0d cycles, required release", nbusy);
                break;
            end
        end
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [4:0] rd);
        int n;
        issue(op, a, b, 32'h0, 1'b0, rd, 1'b1, 1'b0, 1'b0, exp_res, 1);
        wait_accept(n);
    endtask

    task automatic alui(input logic [3:0] op, input logic [31:0] a, input logic [31:0] imm,
                        input logic [31:0] exp_res, input logic [4:0] rd);
        int n;
        issue(op, a, 32'h5A5A5A5A, imm, 1'b1, rd, 1'b1, 1'b0, 1'b0, exp_res, 1);
        wait_accept(n);
    endtask

    task automatic div(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic [4:0] rd,
                       input logic special);
        int n;
        issue(op, a, b, 32'h0, 1'b0, rd, 1'b1, 1'b0, 1'b0, exp_res, special ? 1 : 34);
        wait_accept(n);
        chk(name, 32'(n), special ? 32'd0 : 32'd33);
    endtask

    task automatic gap(input int n);
        ID_EX_Valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_run();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            vecs++;
            errs++;
            $display("FAIL vec%0d: got no output, required res=%h at cycle %0d", e.id, e.res, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    endtask

    initial begin
        #200000;
        vecs++;
        errs++;
        $display("FAIL watchdog: got simulation still running, required completion");
        finish_run();
    end

    initial begin
        int n;
        reset_n = 1'b0; mem_stall = 1'b0; ID_EX_Valid = 1'b0;
        ID_EX_Rs1Data = '0; ID_EX_Rs2Data = '0; ID_EX_Imm = '0; ID_EX_ALUSrc = 1'b0;
        ID_EX_ALUOp = '0; ID_EX_Rd = '0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_MemWrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", EX_MEM_ALUResult, 32'h0);
        chk("reset_ctl", {EX_MEM_WriteData[26:0], EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite} , 32'h0);
        chk("reset_busy", {31'h0, ex_busy}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU sweep
        alu(4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd1);
        alu(4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 5'd2);
        alu(4'd2, 32'h00000001, 32'h0000003F, 32'h80000000, 5'd3);
        alu(4'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'd4);
        alu(4'd4, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 5'd5);
        alu(4'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd6);
        alu(4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 5'd7);
        alu(4'd6, 32'h80000000, 32'h00000004, 32'h08000000, 5'd8);
        alui(4'd7, 32'h80000000, 32'h00000004, 32'hF8000000, 5'd9);
        alu(4'd8, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 5'd10);
        alu(4'd9, 32'h1234FFFF, 32'hFFFF00F0, 32'h123400F0, 5'd11);
        alu(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'd12);
        alu(4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 5'd13);
        alu(4'd11, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 5'd14);
        alu(4'd11, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 5'd15);
        gap(2);

        // Bubble with RegWrite set on the inputs
        ID_EX_Valid = 1'b0; ID_EX_RegWrite = 1'b1; ID_EX_Rd = 5'd5;
        ID_EX_ALUOp = 4'd0; ID_EX_Rs1Data = 32'd1; ID_EX_Rs2Data = 32'd2; ID_EX_ALUSrc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bubble_regwrite", {31'h0, EX_MEM_RegWrite}, 32'h0);
        chk("bubble_result", EX_MEM_ALUResult, 32'h0);
        @(posedge clk);
        #1;

        // Divides, back to back: DIV and REM of -7/2
        div("div_busy_len", 4'd12, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 5'd16, 1'b0);
        div("rem_busy_len", 4'd14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 5'd17, 1'b0);
        div("divu_busy_len", 4'd13, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 5'd18, 1'b0);
        div("remu_busy_len", 4'd15, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 5'd19, 1'b0);
        div("div_min3_busy", 4'd12, 32'h80000000, 32'd3, 32'hD5555556, 5'd20, 1'b0);
        div("rem_min3_busy", 4'd14, 32'h80000000, 32'd3, 32'hFFFFFFFE, 5'd21, 1'b0);

        // Special-case divides complete in one cycle
        div("divu0_busy", 4'd13, 32'd9, 32'd0, 32'hFFFFFFFF, 5'd22, 1'b1);
        div("remu0_busy", 4'd15, 32'd9, 32'd0, 32'h00000009, 5'd23, 1'b1);
        div("rem_ovf_busy", 4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 5'd24, 1'b1);
        div("div_ovf_busy", 4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'd25, 1'b1);
        gap(2);

        // mem_stall for 3 cycles behind a store
        issue(4'd0, 32'h00001000, 32'hCAFEBABE, 32'h00000024, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h00001024, 1);
        wait_accept(n);
        issue(4'd0, 32'd1, 32'd2, 32'h0, 1'b0, 5'd26, 1'b1, 1'b0, 1'b0, 32'd3, 4);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", EX_MEM_ALUResult, 32'h00001024);
            chk("stall_wdata", EX_MEM_WriteData, 32'hCAFEBABE);
            chk("stall_busy", {31'h0, ex_busy}, 32'h1);
            @(posedge clk);
            #1;
        end
        mem_stall = 1'b0;
        wait_accept(n);
        gap(2);

        // mem_stall held 3 cycles in DONE delays the result by exactly 3
        issue(4'd13, 32'd100, 32'd7, 32'h0, 1'b0, 5'd27, 1'b1, 1'b0, 1'b0, 32'd14, 37);
        repeat (33) begin
            @(posedge clk);
            #1;
        end
        mem_stall = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_stall = 1'b0;
        wait_accept(n);
        chk("done_nostall_busy", 32'(n), 32'd0);
        gap(4);

        // mem_stall during BUSY costs no iterations
        issue(4'd15, 32'd100, 32'd7, 32'h0, 1'b0, 5'd28, 1'b1, 1'b0, 1'b0, 32'd2, 34);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        mem_stall = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        mem_stall = 1'b0;
        wait_accept(n);
        gap(2);

        // Reset mid-divide while EX_MEM holds a real result
        alu(4'd5, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 5'd9);
        mem_stall = 1'b1;
        issue(4'd12, 32'd100, 32'd7, 32'h0, 1'b0, 5'd29, 1'b1, 1'b0, 1'b0, 32'd14, 34);
        void'(sbq.pop_back());
        repeat (22) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        chk("rst_mid_result", EX_MEM_ALUResult, 32'h0);
        chk("rst_mid_rd_ctl", {24'h0, EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite}, 32'h0);
        chk("rst_busy_stall", {31'h0, ex_busy}, 32'h1);
        mem_stall = 1'b0;
        #1;
        chk("rst_busy_nostall", {31'h0, ex_busy}, 32'h0);
        @(posedge clk);
        #1;
        ID_EX_Valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        gap(40);
        alu(4'd0, 32'd5, 32'd7, 32'd12, 5'd30);
        gap(4);

        finish_run();
    end

endmodule
